// File: rtl/csr_access_unit.sv
// Zicsr initiator: runs read / modify / conditional-write against the CSR file
// for one decoded instruction at a time and returns the old value for rd.
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_rs1_data,
  input  logic              req_rs1_is_x0,
  input  logic [4:0]        req_zimm,
  output logic [ADDR_W-1:0] csr_sel,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_wen,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_illegal,
  // debug view of the FSM: IDLE=0, READ=1, WRITE=2, RESP=3
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and payload is held while valid=1.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   src_q;
  logic              src_zero_q;
  logic [XLEN-1:0]   old_q;
  logic [XLEN-1:0]   wdata_q;
  logic              illegal_q;

  logic              req_fire;
  logic              req_reserved;
  logic [XLEN-1:0]   src_in;
  logic              src_zero_in;
  logic              wr_intent;
  logic              addr_ro;
  logic [XLEN-1:0]   new_val;

  assign req_fire     = req_valid && (state_q == IDLE);
  assign req_reserved = (req_funct3[1:0] == 2'b00);
  assign src_in       = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1_data;
  assign src_zero_in  = req_funct3[2] ? (req_zimm == 5'd0) : req_rs1_is_x0;

  // RW variants always write; set/clear variants skip the write for a zero source.
  assign wr_intent = (op_q == 2'b01) || !src_zero_q;
  assign addr_ro   = (addr_q[ADDR_W-1 -: 2] == 2'b11);

  always_comb begin
    new_val = csr_rdata & ~src_q;
    case (op_q)
      2'b01:   new_val = src_q;
      2'b10:   new_val = csr_rdata | src_q;
      default: new_val = csr_rdata & ~src_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = req_reserved ? RESP : READ;
      READ:    state_d = (wr_intent && !addr_ro) ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      addr_q     <= '0;
      src_q      <= '0;
      src_zero_q <= 1'b0;
      old_q      <= '0;
      wdata_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        op_q       <= req_funct3[1:0];
        src_q      <= src_in;
        src_zero_q <= src_zero_in;
        // Reserved encodings leave csr_sel untouched: no CSR access is made.
        if (req_reserved) begin
          old_q     <= '0;
          illegal_q <= 1'b1;
        end else begin
          addr_q    <= req_addr;
          illegal_q <= 1'b0;
        end
      end
      if (state_q == READ) begin
        old_q     <= csr_rdata;
        wdata_q   <= new_val;
        illegal_q <= wr_intent && addr_ro;
      end
    end
  end

  // Write enable is a pure state decode, gated by reset so it drops at once.
  assign csr_wen     = rst && (state_q == WRITE);
  assign csr_sel     = addr_q;
  assign csr_wdata   = wdata_q;
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = old_q;
  assign rsp_illegal = illegal_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: behavioural CSR-instruction model with a per-cycle
// monitor, a CSR file model sampling writes on the falling edge, literal pins.
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_data;
  logic        req_rs1_is_x0;
  logic [4:0]  req_zimm;
  logic [11:0] csr_sel;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic [31:0] csr_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic [1:0]  dbg_state;

  csr_access_unit #(.XLEN(32), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_data(req_rs1_data), .req_rs1_is_x0(req_rs1_is_x0),
    .req_zimm(req_zimm), .csr_sel(csr_sel), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .csr_rdata(csr_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [11:0] sel;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        illegal;
    logic        doesw;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [11:0] model_sel;
  logic [11:0] addrs [8];
  int          checks;
  int          errors;

  bit          busy;
  bit          rsp_seen;
  int          cyc;
  int          wen_cnt;
  int          cycle_cnt;
  int          last_acc;
  int          acc_gap;
  int          last_lat;
  int          last_wen_cnt;
  logic [31:0] last_rdata;
  logic [31:0] last_wdata;
  logic        last_ill;

  assign csr_rdata = csr_mem[csr_sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction semantics straight from the Zicsr rules.
  function automatic exp_t model(input logic [2:0] f3, input logic [11:0] a,
                                 input logic [31:0] rs1, input logic x0, input logic [4:0] z);
    exp_t        e;
    logic [31:0] src;
    logic        szero;
    logic        wr;
    src    = f3[2] ? {27'd0, z} : rs1;
    szero  = f3[2] ? (z == 5'd0) : x0;
    e.addr = a;
    if (f3[1:0] == 2'b00) begin
      e.sel = model_sel; e.rdata = 32'd0; e.wdata = 32'd0;
      e.illegal = 1'b1; e.doesw = 1'b0; e.lat = 1;
    end else begin
      wr        = (f3[1:0] == 2'b01) || !szero;
      e.sel     = a;
      e.rdata   = ref_mem[a];
      e.illegal = wr && (a[11:10] == 2'b11);
      e.doesw   = wr && !e.illegal;
      case (f3[1:0])
        2'b01:   e.wdata = src;
        2'b10:   e.wdata = e.rdata | src;
        default: e.wdata = e.rdata & ~src;
      endcase
      e.lat = e.doesw ? 3 : 2;
    end
    return e;
  endfunction

  task automatic commit(input exp_t e, input logic [2:0] f3);
    if (e.doesw) ref_mem[e.addr] = e.wdata;
    if (f3[1:0] != 2'b00) model_sel = e.addr;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    csr_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic scramble();
    req_valid     = 1'($urandom_range(0, 1));
    req_funct3    = 3'($urandom);
    req_addr      = 12'($urandom);
    req_rs1_data  = $urandom;
    req_rs1_is_x0 = 1'($urandom);
    req_zimm      = 5'($urandom);
  endtask

  task automatic mon_pos();
    cycle_cnt++;
    if (!rst) begin
      busy = 0;
      return;
    end
    if (busy) begin
      if (rsp_valid && rsp_ready) begin
        chk("wen_count", 32'(wen_cnt), 32'(cur.doesw));
        last_wen_cnt = wen_cnt;
        busy = 0;
      end else begin
        cyc++;
        if (cyc > 40) begin
          chk("rsp_timeout", 32'(cyc), 32'(cur.lat));
          busy = 0;
        end
      end
    end else if (req_valid && req_ready) begin
      chk("accept_has_exp", 32'(exp_q.size() != 0), 32'd1);
      acc_gap  = cycle_cnt - last_acc;
      last_acc = cycle_cnt;
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        busy = 1; cyc = 1; wen_cnt = 0; rsp_seen = 0;
      end
    end
  endtask

  task automatic mon_neg();
    logic [1:0] es;
    if (!rst) return;
    if (!busy) begin
      chk("idle_req_ready", 32'(req_ready), 32'd1);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_csr_wen", 32'(csr_wen), 32'd0);
      chk("idle_state", 32'(dbg_state), 32'd0);
      return;
    end
    chk("busy_req_ready", 32'(req_ready), 32'd0);
    chk("csr_sel", 32'(csr_sel), 32'(cur.sel));
    chk("csr_wen", 32'(csr_wen), 32'(cur.doesw && cyc == 2));
    if (csr_wen) begin
      chk("csr_wdata", csr_wdata, cur.wdata);
      last_wdata = csr_wdata;
      wen_cnt++;
    end
    es = (cyc >= cur.lat) ? 2'd3 : 2'(cyc);
    chk("state", 32'(dbg_state), 32'(es));
    chk("rsp_valid", 32'(rsp_valid), 32'(cyc >= cur.lat));
    if (rsp_valid) begin
      chk("rsp_rdata", rsp_rdata, cur.rdata);
      chk("rsp_illegal", 32'(rsp_illegal), 32'(cur.illegal));
      if (!rsp_seen) begin
        rsp_seen = 1; last_lat = cyc; last_rdata = rsp_rdata; last_ill = rsp_illegal;
      end
    end
  endtask

  task automatic run_txn(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                         input logic x0, input logic [4:0] z, input int hold);
    exp_t e;
    int   n;
    e = model(f3, a, rs1, x0, z);
    exp_q.push_back(e);
    commit(e, f3);
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1_data = rs1;
    req_rs1_is_x0 = x0; req_zimm = z; rsp_ready = (hold == 0);
    @(posedge clk); #1;
    scramble();
    n = 0;
    while (!rsp_valid && n < 10) begin @(posedge clk); #1; scramble(); n++; end
    chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    repeat (hold) begin @(posedge clk); #1; scramble(); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    exp_t        e;
    logic [2:0]  f3;
    logic [11:0] a;
    logic [31:0] rs1;
    logic        x0;
    logic [4:0]  z;
    int          hold;
    int          mism;

    checks = 0; errors = 0; busy = 0; cyc = 0; wen_cnt = 0; cycle_cnt = 0;
    last_acc = 0; acc_gap = 0; last_lat = 0; last_wen_cnt = 0;
    last_rdata = '0; last_wdata = '0; last_ill = 1'b0; rsp_seen = 0;
    model_sel = '0;
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'hC00, 12'hC01, 12'h7C0, 12'hF11};
    for (int i = 0; i < 4096; i++) begin csr_mem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1; req_valid = 0; req_funct3 = 0; req_addr = 0; req_rs1_data = 0;
    req_rs1_is_x0 = 0; req_zimm = 0; rsp_ready = 0;

    fork
      forever begin @(posedge clk); mon_pos(); @(negedge clk); mon_neg(); end
      forever begin @(negedge clk); if (csr_wen) csr_mem[csr_sel] = csr_wdata; end
    join_none

    #2 rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    chk("rst_csr_wen", 32'(csr_wen), 32'd0);
    chk("rst_csr_sel", 32'(csr_sel), 32'd0);
    chk("rst_csr_wdata", csr_wdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // CSRRS 0x300 (0xF0) with rs1=0x0F
    preload(12'h300, 32'h0000_00F0);
    run_txn(3'b010, 12'h300, 32'h0000_000F, 1'b0, 5'd0, 0);
    chk("rs_rdata", last_rdata, 32'h0000_00F0);
    chk("rs_wdata", last_wdata, 32'h0000_00FF);
    chk("rs_lat", 32'(last_lat), 32'd3);
    chk("rs_wen_cnt", 32'(last_wen_cnt), 32'd1);
    chk("rs_mem", csr_mem[12'h300], 32'h0000_00FF);

    run_txn(3'b111, 12'h300, $urandom, 1'b0, 5'h10, 0);
    chk("rci_wdata", last_wdata, 32'h0000_00EF);
    chk("rci_rdata", last_rdata, 32'h0000_00FF);
    run_txn(3'b111, 12'h300, $urandom, 1'b0, 5'h00, 0);
    chk("rci0_wen_cnt", 32'(last_wen_cnt), 32'd0);
    chk("rci0_lat", 32'(last_lat), 32'd2);
    chk("rci0_rdata", last_rdata, 32'h0000_00EF);

    preload(12'hC00, 32'hABCD_0123);
    run_txn(3'b001, 12'hC00, 32'h5, 1'b0, 5'd0, 0);
    chk("ro_wen_cnt", 32'(last_wen_cnt), 32'd0);
    chk("ro_illegal", 32'(last_ill), 32'd1);
    chk("ro_rdata", last_rdata, 32'hABCD_0123);
    chk("ro_lat", 32'(last_lat), 32'd2);
    run_txn(3'b010, 12'hC00, $urandom, 1'b1, 5'd0, 0);
    chk("ro_read_illegal", 32'(last_ill), 32'd0);
    chk("ro_read_rdata", last_rdata, 32'hABCD_0123);

    run_txn(3'b100, 12'h7C0, $urandom, 1'b0, 5'd3, 0);
    chk("rsv_lat", 32'(last_lat), 32'd1);
    chk("rsv_illegal", 32'(last_ill), 32'd1);
    chk("rsv_rdata", last_rdata, 32'd0);
    chk("rsv_wen_cnt", 32'(last_wen_cnt), 32'd0);
    chk("rsv_sel_kept", 32'(csr_sel), 32'h0000_0C00);

    run_txn(3'b001, 12'h340, 32'hA5A5_5A5A, 1'b0, 5'd0, 0);
    run_txn(3'b001, 12'h340, $urandom, 1'b0, 5'd0, 0);
    chk("b2b_gap", 32'(acc_gap), 32'd4);

    run_txn(3'b001, 12'h341, 32'h1357_9BDF, 1'b0, 5'd0, 5);
    chk("hold_rdata", last_rdata, 32'd0);
    chk("hold_mem", csr_mem[12'h341], 32'h1357_9BDF);

    for (int i = 0; i < 60; i++) begin
      f3   = 3'($urandom_range(0, 7));
      a    = addrs[$urandom_range(0, 7)];
      rs1  = $urandom;
      x0   = ($urandom_range(0, 3) == 0);
      z    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      hold = $urandom_range(0, 3);
      run_txn(f3, a, rs1, x0, z, hold);
    end

    // Reset in the middle of the WRITE cycle of CSRRW 0x305
    preload(12'h305, 32'h1234_5678);
    e = model(3'b001, 12'h305, 32'hDEAD_BEEF, 1'b0, 5'd0);
    exp_q.push_back(e);
    req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h305;
    req_rs1_data = 32'hDEAD_BEEF; req_rs1_is_x0 = 1'b0; req_zimm = 5'd0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_wen", 32'(csr_wen), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(csr_wen), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_csr_sel", 32'(csr_sel), 32'd0);
    chk("mid_rst_csr_wdata", csr_wdata, 32'd0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    model_sel = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("post_rst_mem", csr_mem[12'h305], 32'h1234_5678);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

    run_txn(3'b010, 12'h305, 32'd0, 1'b1, 5'd0, 0);
    chk("post_rst_read", last_rdata, 32'h1234_5678);
    chk("post_rst_lat", 32'(last_lat), 32'd2);

    repeat (2) @(posedge clk);
    mism = 0;
    for (int i = 0; i < 4096; i++) if (csr_mem[i] !== ref_mem[i]) mism++;
    chk("mem_final", 32'(mism), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Initiator side of the CSR register file port. Accepts one decoded Zicsr instruction at a time from the execute stage and performs the read-modify-write sequence against the CSR file: read the old value, compute the new value, then conditionally write it. Returns the old value for `rd` through a valid/ready response. Attempts to write read-only CSRs (address bits [11:10] == 2'b11) and reserved `funct3` encodings are flagged as illegal, and no write is issued for them.

## Interface
Parameters:
- `XLEN`, 32, data width of CSRs and operands
- `ADDR_W`, 12, CSR address width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  instruction request present
- `req_ready`  out  1  unit can accept a request
- `req_funct3`  in  3  Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- `req_addr`  in  ADDR_W  CSR address
- `req_rs1_data`  in  XLEN  register source operand
- `req_rs1_is_x0`  in  1  rs1 field is x0
- `req_zimm`  in  5  immediate source operand
- `csr_sel`  out  ADDR_W  CSR file address
- `csr_wdata`  out  XLEN  CSR file write data
- `csr_wen`  out  1  CSR file write enable
- `csr_rdata`  in  XLEN  CSR file combinational read data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_rdata`  out  XLEN  old CSR value, written back to `rd`
- `rsp_illegal`  out  1  illegal-instruction indication

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. A handshake (`req_valid & req_ready`) latches `funct3`, `addr`, and the source value, then goes to READ.
  - Source value: `funct3[2]` ? zero-extended `zimm` : `rs1_data`.
  - Source-zero flag: `funct3[2]` ? (`zimm`==0) : `req_rs1_is_x0`.
- Illegal conditions:
  - `funct3` of 000 or 100: go directly to RESP with `rsp_illegal`=1 and `rsp_rdata`=0. No CSR access is made.
  - Write intended to an address with [11:10]==2'b11: treated as illegal.
- READ: `csr_sel`=addr and `csr_rdata` is captured into `old`. Write intent is computed here:
  - RW/RWI: always a write.
  - RS/RC/RSI/RCI: write only when the source-zero flag is clear.
- Transition out of READ:
  - Write intended and address read-only: go to RESP with `rsp_illegal`=1 and `rsp_rdata`=`old`.
  - Write intended and address writable: go to WRITE.
  - No write intended: go to RESP.
- New value computation:
  - RW: src
  - RS: old | src
  - RC: old & ~src
- WRITE: `csr_wen`=1 for exactly one cycle, with `csr_sel`=addr and `csr_wdata`=new value, all held stable for the whole cycle (the CSR file samples on the falling edge). Then go to RESP.
- RESP: `rsp_valid`=1, with `rsp_rdata` and `rsp_illegal` held stable until `rsp_ready`. Return to IDLE on the handshake. A new request cannot be accepted in the same cycle.
- At most one outstanding instruction at a time.

## Timing
- Reset (asynchronous, `rst`=0) forces immediately:
  - state IDLE, `req_ready`=1
  - `rsp_valid`=0, `rsp_illegal`=0
  - `csr_wen`=0, `csr_sel`=0, `csr_wdata`=0
  - `rsp_rdata`=0, `old`=0
- Reset during WRITE drops `csr_wen` combinationally in the same cycle, so no partial write reaches the CSR file on the following negedge.
- `csr_wen` is a registered-state decode: high only in WRITE, never glitching in other states.
- Latency from the request handshake in cycle 0:
  - Write path: READ in cycle 1, WRITE in cycle 2, `rsp_valid` first high in cycle 3.
  - No-write or read-only-illegal path: `rsp_valid` first high in cycle 2.
  - Reserved `funct3`: `rsp_valid` first high in cycle 1.
- Throughput: a back-to-back write instruction with `rsp_ready` held at 1 is accepted every 4 cycles.
- `rsp_ready` held low keeps RESP indefinitely, with outputs stable.
- `req_*` inputs are ignored outside IDLE.

## Test plan
- CSR 0x300 preloaded with 0x0000_00F0; CSRRS with rs1_data=0x0F and rs1≠x0:
  - `rsp_rdata`=0x0000_00F0
  - one `csr_wen` pulse with `csr_wdata`=0x0000_00FF
  - `rsp_valid` in cycle 3
- CSRRCI with zimm=0x10 on 0x300 holding 0xFF: `csr_wdata`=0xEF and `rsp_rdata`=0xFF. A second CSRRCI with zimm=0: no `csr_wen`, `rsp_valid` in cycle 2, `rsp_rdata`=0xEF.
- CSRRW to 0xC00 (read-only):
  - `csr_wen` never asserted
  - `rsp_illegal`=1, `rsp_rdata`=old value
  - CSRRS to 0xC00 with rs1=x0: legal read, `rsp_illegal`=0
- `funct3`=100: `rsp_valid` in cycle 1, `rsp_illegal`=1, `csr_wen` never asserted, `csr_sel` unchanged.
- `rsp_ready` held low for 5 cycles after `rsp_valid`:
  - `rsp_valid` and `rsp_rdata` stable throughout
  - `req_ready`=0 throughout
  - new request accepted only in the cycle after the response handshake
- Assert `rst`=0 mid-WRITE of CSRRW 0x305 ← 0xDEADBEEF:
  - `csr_wen` falls within the same cycle and CSR 0x305 is unchanged
  - after release: `req_ready`=1, `rsp_valid`=0
